button_gesture: RTL and testbench

Press-gesture controller downstream of `button_bounce`. Classifies the debounced button level into short-press, long-press and double-click events, and drives a held-level flag. Timed by a one-cycle `tick` enable from the `clk_div` timebase. All logic runs on a single clock, so the debouncer and this block share one timing reference.

---
 rtl/button_pkg.sv | 24 ++
 rtl/button_edge.sv | 32 +++
 rtl/button_gesture.sv | 133 +++++++++++++
 tb/tb_button_gesture.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// button_pkg: shared definitions for the button gesture path.
//   - FSM state encoding (3 bits) as localparams plus a typed enum over them
//   - default timing parameters for button_gesture
package button_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRESS1    = 3'd1;
  localparam logic [2:0] ST_LONG_HOLD = 3'd2;
  localparam logic [2:0] ST_WAIT2     = 3'd3;
  localparam logic [2:0] ST_PRESS2    = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    PRESS1    = ST_PRESS1,
    LONG_HOLD = ST_LONG_HOLD,
    WAIT2     = ST_WAIT2,
    PRESS2    = ST_PRESS2
  } gesture_state_e;

  localparam int LONG_TICKS_DEF   = 16;
  localparam int DCLICK_TICKS_DEF = 8;
  localparam int CNT_W_DEF        = 8;

endpackage

// File: rtl/button_edge.sv
// button_edge: registers a button level and reports its rising/falling edges.
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   d     in  button level, 1 = pressed
//   rise  out d went 0 -> 1 this cycle
//   fall  out d went 1 -> 0 this cycle
// The registered level resets to 1 so a button already held at reset must be
// released before it can produce a rise.
module button_edge
  import button_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q <= 1'b1;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/button_gesture.sv
// button_gesture: classifies a debounced button level into short-press,
// long-press and double-click pulses plus a held-level flag.
//   clk          in  system clock
//   rst_n        in  synchronous active-low reset
//   tick         in  one-clk timebase enable
//   state        in  debounced button level, 1 = pressed
//   short_press  out one-clk pulse
//   long_press   out one-clk pulse
//   double_click out one-clk pulse
//   held         out high while a long press is in progress
//
// state     | meaning
// IDLE      | no gesture in progress, waiting for a press
// PRESS1    | first press down, counting ticks toward a long press
// LONG_HOLD | long press reported, waiting for release
// WAIT2     | first press released, counting ticks for a second press
// PRESS2    | second press down, double click reported on release
module button_gesture
  import button_pkg::*;
#(
  parameter int LONG_TICKS   = LONG_TICKS_DEF,
  parameter int DCLICK_TICKS = DCLICK_TICKS_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic state,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic rise;
  logic fall;

  gesture_state_e fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic short_q, short_d;
  logic long_q, long_d;
  logic dclick_q, dclick_d;
  logic held_q, held_d;

  button_edge u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (state),
    .rise  (rise),
    .fall  (fall)
  );

  always_comb begin
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    dclick_d = 1'b0;

    unique case (fsm_q)
      IDLE: begin
        if (rise) fsm_d = PRESS1;
      end
      PRESS1: begin
        // release wins over expiry landing on the same clk
        if (fall) begin
          fsm_d = WAIT2;
        end else if (tick && cnt_q == LONG_LAST) begin
          fsm_d  = LONG_HOLD;
          long_d = 1'b1;
        end else if (tick && cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LONG_HOLD: begin
        if (fall) fsm_d = IDLE;
      end
      WAIT2: begin
        // second press wins over expiry landing on the same clk
        if (rise) begin
          fsm_d = PRESS2;
        end else if (tick && cnt_q == DCLICK_LAST) begin
          fsm_d   = IDLE;
          short_d = 1'b1;
        end else if (tick && cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESS2: begin
        if (fall) begin
          fsm_d    = IDLE;
          dclick_d = 1'b1;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase

    // every transition restarts the timing window
    if (fsm_d != fsm_q) cnt_d = '0;

    held_d = (fsm_d == LONG_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q    <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      dclick_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      dclick_q <= dclick_d;
      held_q   <= held_d;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_click = dclick_q;
  assign held         = held_q;

endmodule

// File: tb/tb_button_gesture.sv
// tb_button_gesture: directed gesture scenarios followed by randomized button
// and tick activity, every cycle compared against a gesture-level model.
module tb_button_gesture;

  localparam int LONG = 16;
  localparam int DCL  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic state = 1'b0;
  logic short_press, long_press, double_click, held;

  button_gesture #(.LONG_TICKS(LONG), .DCLICK_TICKS(DCL), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .state        (state),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_click (double_click),
    .held         (held)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // tick source: fixed one-in-four or random
  bit rand_tick = 1'b0;
  int tdiv = 0;

  // gesture model: how many presses seen, whether the button is down within
  // the gesture, whether it became a long press, and ticks in the window
  bit m_prev = 1'b1;
  int m_clicks = 0;
  bit m_down = 1'b0;
  bit m_long = 1'b0;
  int m_elapsed = 0;
  bit exp_short, exp_long, exp_dbl, exp_held;

  int seen_short, seen_long, seen_dbl, seen_held;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic gesture_clear();
    m_clicks  = 0;
    m_down    = 1'b0;
    m_long    = 1'b0;
    m_elapsed = 0;
  endtask

  task automatic model_step(input bit s, input bit tk, input bit r);
    bit went_down, went_up;
    exp_short = 1'b0;
    exp_long  = 1'b0;
    exp_dbl   = 1'b0;
    if (!r) begin
      gesture_clear();
      m_prev   = 1'b1;
      exp_held = 1'b0;
      return;
    end
    went_down = s && !m_prev;
    went_up   = !s && m_prev;
    if (m_long) begin
      if (went_up) gesture_clear();
    end else if (m_clicks == 0) begin
      if (went_down) begin
        m_clicks  = 1;
        m_down    = 1'b1;
        m_elapsed = 0;
      end
    end else if (m_clicks == 1 && m_down) begin
      if (went_up) begin
        m_down    = 1'b0;
        m_elapsed = 0;
      end else if (tk) begin
        m_elapsed++;
        if (m_elapsed == LONG) begin
          m_long   = 1'b1;
          exp_long = 1'b1;
        end
      end
    end else if (m_clicks == 1) begin
      if (went_down) begin
        m_clicks = 2;
        m_down   = 1'b1;
      end else if (tk) begin
        m_elapsed++;
        if (m_elapsed == DCL) begin
          exp_short = 1'b1;
          gesture_clear();
        end
      end
    end else begin
      if (went_up) begin
        exp_dbl = 1'b1;
        gesture_clear();
      end
    end
    exp_held = m_long;
    m_prev   = s;
  endtask

  task automatic cyc(input bit s, input bit r, output bit tk);
    if (rand_tick) tk = ($urandom_range(0, 2) == 0);
    else           tk = (tdiv == 3);
    tdiv  = (tdiv + 1) % 4;
    state = s;
    rst_n = r;
    tick  = tk;
    @(posedge clk);
    model_step(s, tk, r);
    #1;
    chk("short_press",  32'(short_press),  32'(exp_short));
    chk("long_press",   32'(long_press),   32'(exp_long));
    chk("double_click", 32'(double_click), 32'(exp_dbl));
    chk("held",         32'(held),         32'(exp_held));
    seen_short += int'(short_press === 1'b1);
    seen_long  += int'(long_press === 1'b1);
    seen_dbl   += int'(double_click === 1'b1);
    seen_held  += int'(held === 1'b1);
  endtask

  // apply level s until n tick cycles have gone by (ends on a tick cycle)
  task automatic hold(input bit s, input int n);
    int k;
    bit t;
    k = 0;
    while (k < n) begin
      cyc(s, 1'b1, t);
      if (t) k++;
    end
  endtask

  task automatic reset_cycles(input bit s, input int n);
    bit t;
    for (int i = 0; i < n; i++) cyc(s, 1'b0, t);
  endtask

  task automatic scen_begin();
    seen_short = 0;
    seen_long  = 0;
    seen_dbl   = 0;
    seen_held  = 0;
  endtask

  task automatic scen_end(input string tag, input int es, input int el,
                          input int ed, input int eh);
    chk({tag, ".short_count"},  32'(seen_short), 32'(es));
    chk({tag, ".long_count"},   32'(seen_long),  32'(el));
    chk({tag, ".dclick_count"}, 32'(seen_dbl),   32'(ed));
    chk({tag, ".held_seen"},    32'(seen_held > 0), 32'(eh));
  endtask

  initial begin
    bit t;
    // reset for 4 clk with button released
    scen_begin();
    reset_cycles(1'b0, 4);
    scen_end("reset", 0, 0, 0, 0);

    // 1: short press
    scen_begin();
    hold(1'b0, 2);
    hold(1'b1, 5);
    hold(1'b0, 12);
    scen_end("short", 1, 0, 0, 0);

    // 2: long press
    scen_begin();
    hold(1'b1, 20);
    hold(1'b0, 2);
    scen_end("long", 0, 1, 0, 1);

    // 3: double click
    scen_begin();
    hold(1'b1, 3);
    hold(1'b0, 3);
    hold(1'b1, 2);
    hold(1'b0, 10);
    scen_end("dclick", 0, 0, 1, 0);

    // 4: release on the same clk as the 16th tick
    scen_begin();
    hold(1'b0, 2);
    hold(1'b1, 15);
    while (tdiv != 3) cyc(1'b1, 1'b1, t);
    cyc(1'b0, 1'b1, t);
    chk("race.release_on_tick", 32'(t), 32'd1);
    hold(1'b0, 10);
    scen_end("race", 1, 0, 0, 0);

    // 5: pressed across reset release
    scen_begin();
    reset_cycles(1'b1, 4);
    hold(1'b1, 25);
    scen_end("held_at_reset", 0, 0, 0, 0);
    scen_begin();
    hold(1'b0, 2);
    hold(1'b1, 5);
    hold(1'b0, 12);
    scen_end("after_reset", 1, 0, 0, 0);

    // 6: reset mid PRESS1
    scen_begin();
    hold(1'b0, 2);
    hold(1'b1, 10);
    reset_cycles(1'b1, 4);
    hold(1'b1, 20);
    hold(1'b0, 12);
    scen_end("mid_reset", 0, 0, 0, 0);
    scen_begin();
    hold(1'b1, 5);
    hold(1'b0, 12);
    scen_end("mid_reset_recover", 1, 0, 0, 0);

    // randomized activity: fixed tick phase first, then random ticks
    for (int seg = 0; seg < 300; seg++) begin
      bit s, r;
      int len;
      rand_tick = (seg >= 150);
      r   = ($urandom_range(0, 39) != 0);
      s   = 1'($urandom_range(0, 1));
      len = r ? $urandom_range(1, 80) : $urandom_range(1, 3);
      for (int i = 0; i < len; i++) cyc(s, r, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
